// File: rtl/sensor_monitor.sv
// Multi-channel debounced sensor alarm monitor with any-alarm flag and saturating event counter.
// Optional feature: define SENSOR_MONITOR_SYNC_EN to pass X through a 2-flop synchroniser.
module sensor_monitor #(
  parameter int CH      = 4,
  parameter int SET_CNT = 3,
  parameter int CLR_CNT = 3,
  parameter int CW      = 8
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic [CH-1:0] X,
  input  logic          LATCH,
  input  logic [CH-1:0] ACK,
  output logic [CH-1:0] Z,
  output logic          ANY,
  output logic          EVT,
  output logic [CW-1:0] EVT_CNT
);

  localparam int MAX_CNT = (SET_CNT > CLR_CNT) ? SET_CNT : CLR_CNT;
  localparam int CTW     = $clog2(MAX_CNT + 1);

  localparam logic [CTW-1:0] SET_T = CTW'(SET_CNT);
  localparam logic [CTW-1:0] CLR_T = CTW'(CLR_CNT);

  // Bit 1 of the encoding doubles as the Moore alarm output (ALARM and PCLR).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PSET  = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;
  localparam logic [1:0] PCLR  = 2'd3;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [CH-1:0] x_fsm;

`ifdef SENSOR_MONITOR_SYNC_EN
  logic [CH-1:0] x_p0;
  logic [CH-1:0] x_p1;

  // Synchroniser stages; reset to the inactive level so reset does not look like a trip.
  always_ff @(posedge CLK) begin
    if (MR) begin
      x_p0 <= '1;
      x_p1 <= '1;
    end else begin
      x_p0 <= X;
      x_p1 <= x_p0;
    end
  end

  assign x_fsm = x_p1;
`else
  assign x_fsm = X;
`endif

  logic [1:0]     state     [CH];
  logic [1:0]     state_nxt [CH];
  logic [CTW-1:0] cnt       [CH];
  logic [CTW-1:0] cnt_nxt   [CH];
  logic [CH-1:0]  z_nxt;
  logic [CH-1:0]  entry;

  // IDLE and ALARM always hold cnt=0, so each shares its qualification path with PSET/PCLR.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE, PSET: begin
          if (!x_fsm[i]) begin
            if (cnt[i] + CTW'(1) == SET_T) begin
              state_nxt[i] = ALARM;
              cnt_nxt[i]   = '0;
            end else begin
              state_nxt[i] = PSET;
              cnt_nxt[i]   = cnt[i] + CTW'(1);
            end
          end else begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end
        end
        default: begin
          if (LATCH) begin
            cnt_nxt[i] = '0;
            if (state[i] == ALARM && ACK[i] && x_fsm[i]) begin
              state_nxt[i] = IDLE;
            end else begin
              state_nxt[i] = ALARM;
            end
          end else if (x_fsm[i]) begin
            if (cnt[i] + CTW'(1) == CLR_T) begin
              state_nxt[i] = IDLE;
              cnt_nxt[i]   = '0;
            end else begin
              state_nxt[i] = PCLR;
              cnt_nxt[i]   = cnt[i] + CTW'(1);
            end
          end else begin
            state_nxt[i] = ALARM;
            cnt_nxt[i]   = '0;
          end
        end
      endcase
      z_nxt[i] = state_nxt[i][1];
      entry[i] = !state[i][1] && (state_nxt[i] == ALARM);
    end
  end

  // Channel state and aggregate outputs, all registered from next-state values.
  always_ff @(posedge CLK) begin
    if (MR) begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= ALARM;
        cnt[i]   <= '0;
      end
      Z       <= '1;
      ANY     <= 1'b1;
      EVT     <= 1'b0;
      EVT_CNT <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      Z   <= z_nxt;
      ANY <= |z_nxt;
      EVT <= |entry;
      if (|entry) begin
        EVT_CNT <= sat_inc(EVT_CNT);
      end
    end
  end

endmodule
